// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes,
// digit count and scan state encoding.
package seg_pkg;

   localparam int unsigned DIGITS = 4;

   // Active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
   localparam logic [6:0] SEG_LUT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } scan_state_e;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
      if (nib < 4'd10) return SEG_LUT[nib];
      return SEG_DASH;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a single-cycle rising-edge pulse.
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic pulse_o
);

   logic s1_q, s2_q, prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver advanced by a slow scan clock,
// with a one-entry input buffer loaded into the display only at frame start.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        basys3_clock,
   input  logic        rst_n,
   input  logic        scan_clk,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic [15:0] din,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   logic tick;

   sync_edge_detect u_sync (
      .clk_i  (basys3_clock),
      .rst_ni (rst_n),
      .d_i    (scan_clk),
      .pulse_o(tick)
   );

   scan_state_e state_q, state_d;
   logic [15:0] pending_q, pending_d, shadow_q, shadow_d, upper;
   logic [3:0]  pending_dp_q, pending_dp_d, shadow_dp_q, shadow_dp_d;
   logic        pending_full_q, pending_full_d;
   logic        ready_q, ready_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d, fd_q, fd_d;
   logic        accept, load, blank;
   logic [1:0]  k;
   logic [3:0]  nib;

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      pending_dp_d   = pending_dp_q;
      pending_full_d = pending_full_q;
      shadow_d       = shadow_q;
      shadow_dp_d    = shadow_dp_q;
      an_d           = an_q;
      seg_d          = seg_q;
      dp_d           = dp_q;
      fd_d           = 1'b0;
      k              = state_q;
      upper          = '0;
      nib            = '0;
      blank          = 1'b0;

      // accept needs an empty buffer and load a full one, so they never coincide
      accept = din_valid && ready_q;
      load   = tick && (state_q == S0) && pending_full_q;

      if (load) begin
         shadow_d       = pending_q;
         shadow_dp_d    = pending_dp_q;
         pending_full_d = 1'b0;
      end
      if (accept) begin
         pending_d      = din;
         pending_dp_d   = dp_in;
         pending_full_d = 1'b1;
      end

      if (tick) begin
         upper = shadow_d >> {k, 2'b00};
         nib   = shadow_d[{k, 2'b00} +: 4];
         blank = BLANK_LZ && (k != 2'd0) && (upper == 16'h0000) && !shadow_dp_d[k];
         an_d  = ~(4'b0001 << k);
         seg_d = blank ? SEG_BLANK : bcd_to_seg(nib);
         dp_d  = ~shadow_dp_d[k];
         fd_d  = (k == 2'(DIGITS - 1));
         case (state_q)
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            default: state_d = S0;
         endcase
      end

      ready_d = !pending_full_d;
   end

   always_ff @(posedge basys3_clock) begin
      if (!rst_n) begin
         state_q        <= S0;
         pending_q      <= '0;
         pending_dp_q   <= '0;
         pending_full_q <= 1'b0;
         shadow_q       <= '0;
         shadow_dp_q    <= '0;
         ready_q        <= 1'b0;
         an_q           <= '1;
         seg_q          <= SEG_BLANK;
         dp_q           <= 1'b1;
         fd_q           <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         pending_dp_q   <= pending_dp_d;
         pending_full_q <= pending_full_d;
         shadow_q       <= shadow_d;
         shadow_dp_q    <= shadow_dp_d;
         ready_q        <= ready_d;
         an_q           <= an_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         fd_q           <= fd_d;
      end
   end

   assign din_ready  = ready_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: reset, scanning, blanking, tear-free
// loading, accept/load collision, invalid codes and reset mid-frame.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n, scan_clk, din_valid;
   logic        din_ready, dp, frame_done;
   logic [15:0] din;
   logic [3:0]  dp_in, an;
   logic [6:0]  seg;

   int n_chk = 0;
   int n_err = 0;

   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                          G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                          G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                          G9 = 7'b0010000, GB = 7'h7F, GD = 7'b0111111;

   seg_scan_driver #(.DIGITS(4), .BLANK_LZ(1'b1)) dut (
      .basys3_clock(clk),
      .rst_n       (rst_n),
      .scan_clk    (scan_clk),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .din         (din),
      .dp_in       (dp_in),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic [3:0] dpm, input logic exp_ready);
      @(negedge clk);
      din       = d;
      dp_in     = dpm;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      chk("ready_after_offer", {15'b0, din_ready}, {15'b0, exp_ready});
   endtask

   // One scan_clk period; optionally offers coll_d in the tick cycle.
   task automatic scan_digit(input int k, input logic [6:0] s, input logic d,
                             input bit coll, input logic [15:0] coll_d);
      @(negedge clk);
      scan_clk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      if (coll) begin
         @(negedge clk);
         din       = coll_d;
         dp_in     = 4'b0000;
         din_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      chk($sformatf("an_d%0d", k),  {12'b0, an},  {12'b0, an_tab[k]});
      chk($sformatf("seg_d%0d", k), {9'b0, seg},  {9'b0, s});
      chk($sformatf("dp_d%0d", k),  {15'b0, dp},  {15'b0, d});
      chk($sformatf("fd_d%0d", k),  {15'b0, frame_done}, {15'b0, (k == 3)});
      @(negedge clk);
      chk("fd_one_cycle", {15'b0, frame_done}, 16'h0000);
      @(negedge clk);
      scan_clk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic scan_frame(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dpm);
      scan_digit(0, s0, ~dpm[0], 1'b0, 16'h0);
      scan_digit(1, s1, ~dpm[1], 1'b0, 16'h0);
      scan_digit(2, s2, ~dpm[2], 1'b0, 16'h0);
      scan_digit(3, s3, ~dpm[3], 1'b0, 16'h0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_an",    {12'b0, an},  16'h000F);
      chk("rst_seg",   {9'b0, seg},  16'h007F);
      chk("rst_dp",    {15'b0, dp},  16'h0001);
      chk("rst_fd",    {15'b0, frame_done}, 16'h0000);
      chk("rst_ready", {15'b0, din_ready},  16'h0000);
   endtask

   initial begin
      rst_n = 1'b0; scan_clk = 1'b0; din_valid = 1'b0; din = '0; dp_in = '0;

      // Reset with scan_clk toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         scan_clk = ~scan_clk;
      end
      @(negedge clk);
      scan_clk = 1'b0;
      chk_reset_outputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", {15'b0, din_ready}, 16'h0001);

      // Single load and two frames
      send(16'h1234, 4'b0100, 1'b0);
      scan_digit(0, G4, 1'b1, 1'b0, 16'h0);
      chk("ready_after_load", {15'b0, din_ready}, 16'h0001);
      scan_digit(1, G3, 1'b1, 1'b0, 16'h0);
      scan_digit(2, G2, 1'b0, 1'b0, 16'h0);
      scan_digit(3, G1, 1'b1, 1'b0, 16'h0);
      scan_frame(G1, G2, G3, G4, 4'b0100);

      // Leading-zero blanking
      send(16'h0007, 4'b0000, 1'b0);
      scan_frame(GB, GB, GB, G7, 4'b0000);
      send(16'h0000, 4'b0000, 1'b0);
      scan_frame(GB, GB, GB, G0, 4'b0000);

      // Tear-free load offered in S2, second offer while full ignored
      send(16'h9876, 4'b0000, 1'b0);
      scan_frame(G9, G8, G7, G6, 4'b0000);
      scan_digit(0, G6, 1'b1, 1'b0, 16'h0);
      scan_digit(1, G7, 1'b1, 1'b0, 16'h0);
      send(16'h5555, 4'b0000, 1'b0);
      send(16'h1111, 4'b1111, 1'b0);
      scan_digit(2, G8, 1'b1, 1'b0, 16'h0);
      scan_digit(3, G9, 1'b1, 1'b0, 16'h0);
      scan_frame(G5, G5, G5, G5, 4'b0000);
      chk("ready_after_5555", {15'b0, din_ready}, 16'h0001);
      scan_frame(G5, G5, G5, G5, 4'b0000);

      // Accept coinciding with S0 tick, pending empty
      scan_digit(0, G5, 1'b1, 1'b1, 16'h0042);
      chk("ready_after_coll", {15'b0, din_ready}, 16'h0000);
      scan_digit(1, G5, 1'b1, 1'b0, 16'h0);
      scan_digit(2, G5, 1'b1, 1'b0, 16'h0);
      scan_digit(3, G5, 1'b1, 1'b0, 16'h0);
      scan_frame(GB, GB, G4, G2, 4'b0000);

      // Invalid BCD codes
      send(16'hFA00, 4'b0000, 1'b0);
      scan_frame(GD, GD, G0, G0, 4'b0000);

      // Reset mid-frame with a value pending
      scan_digit(0, G0, 1'b1, 1'b0, 16'h0);
      scan_digit(1, G0, 1'b1, 1'b0, 16'h0);
      send(16'h1234, 4'b0000, 1'b0);
      @(negedge clk);
      scan_clk = 1'b1;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rr_an",    {12'b0, an},  16'h000E);
      chk("rr_seg",   {9'b0, seg},  {9'b0, G0});
      chk("rr_dp",    {15'b0, dp},  16'h0001);
      chk("rr_ready", {15'b0, din_ready}, 16'h0001);
      repeat (2) @(negedge clk);
      scan_clk = 1'b0;
      repeat (4) @(negedge clk);
      scan_digit(1, GB, 1'b1, 1'b0, 16'h0);
      scan_digit(2, GB, 1'b1, 1'b0, 16'h0);
      scan_digit(3, GB, 1'b1, 1'b0, 16'h0);
      scan_digit(0, G0, 1'b1, 1'b0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Four-digit seven-segment scan driver sitting directly downstream of the programmable clock divider. It treats the divider's slow square-wave output as a data input, synchronises it and detects its rising edges to advance the digit scan. It drives the Basys3 anode and segment pins from a tear-free, frame-aligned shadow copy of a BCD value. New values are accepted through a one-entry valid/ready buffer.

## Interface
- `DIGITS`, 4: number of scanned digits; the design is fixed at 4, and the parameter is for package consistency only.
- `BLANK_LZ`, 1: 1 enables leading-zero blanking.
- `basys3_clock` in 1: the only clock, 100 MHz board clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `scan_clk` in 1: divider output (slow square wave); asynchronous to logic, treated as data.
- `din_valid` in 1: a new display value is offered.
- `din_ready` out 1: one-entry buffer is empty.
- `din` in 16: four BCD nibbles, `[3:0]` = digit 0 (rightmost).
- `dp_in` in 4: decimal-point request per digit, captured with `din`.
- `an` out 4: anodes, active-low, one-hot-low while scanning.
- `seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `frame_done` out 1: one-cycle pulse after digit 3 is driven.

## Operation
- **Synchroniser and tick.** `scan_clk` passes through a 2-FF synchroniser and then a rising-edge detector. This produces `tick`, one cycle wide per `scan_clk` rising edge.
- **Scan state.** Digit index `idx` walks S0→S1→S2→S3→S0, advancing only on `tick`.
  - On a tick in state Sk, the block drives digit k and moves to Sk+1 (S3 wraps to S0).
- **Handshake.**
  - `din_ready` = !pending_full.
  - The transfer occurs when `din_valid && din_ready`: `din`/`dp_in` are latched into pending, and pending_full is set.
  - `din` is ignored while `din_ready` is 0.
- **Frame load.** On a tick in S0 with pending_full set:
  - shadow ← pending and pending_full is cleared, both in the same cycle;
  - digit 0 of this frame is decoded from the new value.
  - A frame (S0..S3) therefore always shows one consistent value.
- **Accept/load collision.** If an accept and an S0 tick coincide with pending empty, the new value goes to pending only. It is loaded at the next S0 tick.
- **Decode.**
  - Nibbles 0-9 use the standard LUT.
  - Nibbles A-F show a dash (`7'b0111111`).
- **Leading-zero blanking** (`BLANK_LZ`=1):
  - Digit k (k = 3..1) is blanked (`seg`=`7'h7F`, anode still driven) when it and all higher digits are 0 and its dp bit is 0.
  - Digit 0 is never blanked.
- **Decimal point.** `dp` = ~shadow_dp[k] for the digit being driven.
- **`frame_done`.** Pulses for the cycle after the S3 tick.

## Timing
- **Reset values** (register state after a clock edge with `rst_n`=0):
  - `an`=`4'b1111`, `seg`=`7'h7F`, `dp`=1, `frame_done`=0, `din_ready`=0.
  - `idx`=S0, shadow=0, shadow dp=0, pending_full=0, synchroniser and edge registers=0.
- `din_ready` rises on the first cycle after reset release.
- **Latency.** `an`/`seg`/`dp` update on the 3rd `basys3_clock` rising edge after the first edge that samples `scan_clk` high: 2 synchroniser edges + 1 output register edge.
- **Handshake.** `din_ready` falls 1 cycle after an accept. It rises 1 cycle after the S0 load tick.
- **Reset mid-operation.**
  - All state returns to reset values on the next edge, and any pending value is discarded.
  - If `scan_clk` is high at release, a tick is generated 2 cycles after release and drives digit 0.
- **`scan_clk` rate.** `scan_clk` must have high and low phases of ≥3 `basys3_clock` cycles each. Faster input may drop ticks; this is not checked.
- **Register duration.** `tick` and `frame_done` are never high for 2 consecutive cycles. All outputs are registered.

## Structure
- **Shared package `seg_pkg`:**
  - BCD-to-segment LUT constants;
  - `SEG_BLANK` (`7'h7F`) and `SEG_DASH`;
  - `DIGITS`;
  - scan state encodings S0..S3.
- **Sub-module `sync_edge_detect`:** 2-FF synchroniser plus rising-edge pulse, with synchronous active-low reset. It is reusable for buttons and other divider outputs.
- Remainder stays in one module:
  - scan FSM;
  - pending/shadow buffers;
  - decode and blanking.

## Test plan
- **Reset.** Hold `rst_n`=0 for 5 cycles with `scan_clk` toggling → `an`=`1111`, `seg`=`7F`, `dp`=1, `din_ready`=0. After release, `din_ready`=1 on the next cycle.
- **Single load and scan.** Accept `din`=`16'h1234`, `dp_in`=`4'b0100`, then 8 `scan_clk` periods:
  - `an` walks `1110,1101,1011,0111` twice;
  - `seg` = 4, 3, 2, 1 → `7'b0011001`, `0110000`, `0100100`, `1111001`;
  - `dp`=0 only on digit 2;
  - `frame_done` pulses twice.
- **Leading zeros.** `din`=`16'h0007` → digits 3..1 show `seg`=`7F` and digit 0 shows `7'b1111000`. Then `din`=`16'h0000` → only digit 0 shows `7'b1000000`.
- **Tear-free load.**
  - Offer `16'h5555` mid-frame in S2; `din_ready` drops.
  - Digits 2 and 3 keep the old value; the new value appears from the next digit 0.
  - A second `din_valid` while full is ignored.
- **Collision and invalid codes.** `din_valid` is asserted in the same cycle as an S0 tick with pending empty → the value is displayed from the following frame, not this one. `din`=`16'hFA00` → digits 3 and 2 show a dash.
- **Reset mid-frame.** Assert `rst_n`=0 during S2 with a value pending → outputs return to reset values. After release with `scan_clk` high, the first tick drives `an`=`1110` with shadow=0 (`seg`=`7'b1000000`).
